// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dds_sweep_ctrl
//  Brief    : Linear frequency-sweep controller for the dds phase-accumulator
//             core. It steps fword from a start word to a stop word
//             (inclusive). Each word is held for a programmable dwell. Sweeps
//             run once or repeat continuously.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FW_W     frequency-word width (matches dds.fword)
//    PW_W     phase-word width (matches dds.pword)
//    DWELL_W  dwell counter width
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    start      in   one-cycle sweep request, honoured only when idle
//    abort      in   stop the sweep at the next edge; beats start
//    mode       in   0 = single sweep, 1 = continuous (wrap to f_start)
//    f_start    in   first frequency word
//    f_stop     in   last permitted frequency word (inclusive)
//    f_step     in   increment per step
//    dwell      in   cycles per frequency (0 behaves as 1)
//    p_offset   in   phase word, registered through to pword
//    fword      out  to dds.fword
//    pword      out  to dds.pword
//    en         out  to dds.en
//    busy       out  sweep active
//    step_tick  out  pulse in each cycle where fword takes a new value
//    done       out  pulse at the natural end of a single sweep
//    cfg_err    out  pulse when a start is rejected (f_stop < f_start)
// ============================================================================
module dds_sweep_ctrl #(
  parameter int FW_W    = 32,
  parameter int PW_W    = 12,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [FW_W-1:0]    f_start,
  input  logic [FW_W-1:0]    f_stop,
  input  logic [FW_W-1:0]    f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [PW_W-1:0]    p_offset,
  output logic [FW_W-1:0]    fword,
  output logic [PW_W-1:0]    pword,
  output logic               en,
  output logic               busy,
  output logic               step_tick,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [DWELL_W-1:0] c_cnt_one = DWELL_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [DWELL_W-1:0]   r_cnt;

  // Shadow copy of the configuration. It is taken when a start is accepted.
  // The live inputs are then free to change without disturbing the sweep.
  logic [FW_W-1:0]      r_f_start;
  logic [FW_W-1:0]      r_f_stop;
  logic [FW_W-1:0]      r_f_step;
  logic [DWELL_W-1:0]   r_dwell;
  logic                 r_mode;

  logic                 w_cfg_ok;
  logic [DWELL_W-1:0]   w_dwell_eff;
  logic [FW_W:0]        w_nxt;
  logic                 w_step_ok;
  logic                 w_dwell_end;

  // The start request is checked against the live inputs, because the shadow
  // registers only load once the request is accepted.
  assign w_cfg_ok    = (f_stop >= f_start);

  // A dwell of 0 is stored as 1. The run-time compare then needs no special case.
  assign w_dwell_eff = (dwell == '0) ? c_cnt_one : dwell;

  // The next candidate word is formed one bit wider than fword. A carry out
  // of the top bit then compares greater than f_stop. It can never wrap to
  // a small value that would pass the limit test.
  assign w_nxt       = {1'b0, fword} + {1'b0, r_f_step};
  assign w_step_ok   = (r_f_step != '0) && (w_nxt <= {1'b0, r_f_stop});
  assign w_dwell_end = (r_cnt == r_dwell);

  // --------------------------------------------------------------------------
  // Sweep sequencer. All outputs are registered. The pulse outputs default
  // low every cycle, so each one lasts exactly one clock.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_f_start <= '0;
      r_f_stop  <= '0;
      r_f_step  <= '0;
      r_dwell   <= '0;
      r_mode    <= 1'b0;
      fword     <= '0;
      en        <= 1'b0;
      busy      <= 1'b0;
      step_tick <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // start together with abort is dropped entirely. This also
          // suppresses the configuration check and any cfg_err pulse.
          if (start && !abort) begin
            if (w_cfg_ok) begin
              r_f_start <= f_start;
              r_f_stop  <= f_stop;
              r_f_step  <= f_step;
              r_dwell   <= w_dwell_eff;
              r_mode    <= mode;
              fword     <= f_start;
              en        <= 1'b1;
              busy      <= 1'b1;
              step_tick <= 1'b1;
              r_cnt     <= c_cnt_one;
              r_state   <= S_RUN;
            end else begin
              cfg_err   <= 1'b1;
            end
          end
        end

        S_RUN: begin
          // abort is checked first. It also beats the end of the final
          // dwell, so an aborted sweep never produces done. fword keeps
          // its current value.
          if (abort) begin
            en      <= 1'b0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_dwell_end) begin
            if (w_step_ok) begin
              fword     <= w_nxt[FW_W-1:0];
              r_cnt     <= c_cnt_one;
              step_tick <= 1'b1;
            end else if (r_mode) begin
              // In continuous mode the sweep wraps to f_start. This also
              // applies when f_step is zero, so f_start is reloaded and
              // step_tick pulses every dwell period.
              fword     <= r_f_start;
              r_cnt     <= c_cnt_one;
              step_tick <= 1'b1;
            end else begin
              en      <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        default: begin
          r_state <= S_IDLE;
          en      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // The phase word is a plain registered pass-through. It is independent of
  // the sweep state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pword <= '0;
    end else begin
      pword <= p_offset;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_sweep_ctrl
//  Brief    : Self-checking bench for dds_sweep_ctrl. Table-driven single
//             sweeps feed a cycle-by-cycle scoreboard. Hand-written sequences
//             cover wrap, abort, collisions, start rejection and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] f_start = '0;
  logic [31:0] f_stop = '0;
  logic [31:0] f_step = '0;
  logic [15:0] dwell = '0;
  logic [11:0] p_offset = '0;
  logic [31:0] fword;
  logic [11:0] pword;
  logic        en, busy, step_tick, done, cfg_err;

  dds_sweep_ctrl #(.FW_W(32), .PW_W(12), .DWELL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .p_offset(p_offset), .fword(fword), .pword(pword), .en(en),
    .busy(busy), .step_tick(step_tick), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        busy;
    logic        step_tick;
    logic        done;
    logic        cfg_err;
    logic [11:0] pword;
    logic [31:0] fword;
  } obs_t;

  typedef struct {
    logic [31:0] fs;
    logic [31:0] fe;
    logic [31:0] st;
    logic [15:0] dw;
    logic [11:0] po;
    int          exp_k;
    logic [31:0] exp_last;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tick_cnt;
  obs_t sb_q[$];
  vec_t tbl[5];

  localparam logic [31:0] V1 = 32'd42949672;
  localparam logic [31:0] V2 = 32'd85899344;
  localparam logic [31:0] V3 = 32'd128849016;

  function automatic obs_t sample();
    return {en, busy, step_tick, done, cfg_err, pword, fword};
  endfunction

  function automatic obs_t mk(logic e, logic b, logic t, logic d, logic c,
                              logic [11:0] p, logic [31:0] f);
    obs_t o;
    o.en = e; o.busy = b; o.step_tick = t; o.done = d; o.cfg_err = c;
    o.pword = p; o.fword = f;
    return o;
  endfunction

  task automatic check(string name, obs_t got, obs_t req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got en=%b busy=%b tick=%b done=%b err=%b pword=%h fword=%h, required en=%b busy=%b tick=%b done=%b err=%b pword=%h fword=%h",
               name, got.en, got.busy, got.step_tick, got.done, got.cfg_err, got.pword, got.fword,
               req.en, req.busy, req.step_tick, req.done, req.cfg_err, req.pword, req.fword);
    end
  endtask

  task automatic check_int(string name, int got, int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Pop n expected records. Compare one per cycle at the falling edge.
  task automatic drain_n(string name, int n);
    obs_t e_obs;
    obs_t got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: scoreboard empty, got fword=%h, required a queued record", name, fword);
        return;
      end
      e_obs = sb_q.pop_front();
      got   = sample();
      if (got.step_tick) tick_cnt++;
      check(name, got, e_obs);
    end
  endtask

  task automatic drain(string name);
    drain_n(name, sb_q.size());
  endtask

  // Drive a start for one edge. Afterwards scramble the configuration
  // inputs, so the sweep only completes correctly from the captured copy.
  task automatic do_start(logic [31:0] fs, logic [31:0] fe, logic [31:0] st,
                          logic [15:0] dw, logic md, logic [11:0] po);
    @(negedge clk);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; mode = md;
    p_offset = po; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    f_start = 32'hDEAD_BEEF; f_stop = 32'h0; f_step = 32'h1;
    dwell = 16'd9; mode = ~md;
  endtask

  // Closed-form single-sweep model. Word i is fs + i*st for
  // i < K = floor((fe-fs)/st)+1, or K = 1 when st = 0. Each word is held for
  // max(dw,1) cycles. It is followed by a done cycle and a quiet idle cycle.
  task automatic push_single(vec_t v);
    longint d, k;
    logic [31:0] val;
    d = (v.dw == 0) ? 1 : longint'(v.dw);
    if (v.st == 0) k = 1;
    else k = (longint'(v.fe) - longint'(v.fs)) / longint'(v.st) + 1;
    val = v.fs;
    for (longint i = 0; i < k; i++) begin
      val = 32'(longint'(v.fs) + i * longint'(v.st));
      for (longint c = 0; c < d; c++)
        sb_q.push_back(mk(1'b1, 1'b1, (c == 0), 1'b0, 1'b0, v.po, val));
    end
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v.po, val));
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v.po, val));
  endtask

  task automatic run_vec(string name, vec_t v);
    tick_cnt = 0;
    do_start(v.fs, v.fe, v.st, v.dw, 1'b0, v.po);
    push_single(v);
    drain(name);
    check_int({name, "_ticks"}, tick_cnt, v.exp_k);
    check_int({name, "_last"}, int'(fword), int'(v.exp_last));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            fs             fe             st          dw     po      K  last
    tbl[0] = '{32'd100,       32'd400,       32'd100,   16'd3, 12'h111, 4, 32'd400};
    tbl[1] = '{32'd0,         32'd250,       32'd100,   16'd0, 12'h222, 3, 32'd200};
    tbl[2] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80,    16'd2, 12'h333, 2, 32'hFFFF_FF80};
    tbl[3] = '{32'd5,         32'd5,         32'd0,     16'd2, 12'h444, 1, 32'd5};
    tbl[4] = '{32'd7,         32'd7,         32'd1,     16'd1, 12'h555, 1, 32'd7};

    // Reset: the asynchronous assertion clears the outputs, and pword stays 0
    // while reset is held.
    p_offset = 12'h5A5;
    #3 rst_n = 1'b0;
    #1 check("reset_async", sample(), mk(0, 0, 0, 0, 0, 12'h000, 32'h0));
    @(negedge clk);
    check("reset_hold", sample(), mk(0, 0, 0, 0, 0, 12'h000, 32'h0));
    rst_n = 1'b1;
    @(negedge clk);
    check("pword_pass", sample(), mk(0, 0, 0, 0, 0, 12'h5A5, 32'h0));

    for (int i = 0; i < 5; i++)
      run_vec($sformatf("single%0d", i), tbl[i]);

    // Continuous wrap over three words with dwell 2. A start with a bad
    // configuration is issued mid-sweep; it must be ignored with no cfg_err.
    // abort arrives in the 5th step.
    do_start(V1, V3, V1, 16'd2, 1'b1, 12'h123);
    begin
      logic [31:0] seq[5];
      seq[0] = V1; seq[1] = V2; seq[2] = V3; seq[3] = V1; seq[4] = V2;
      for (int s = 0; s < 4; s++) begin
        sb_q.push_back(mk(1, 1, 1, 0, 0, 12'h123, seq[s]));
        sb_q.push_back(mk(1, 1, 0, 0, 0, 12'h123, seq[s]));
      end
      sb_q.push_back(mk(1, 1, 1, 0, 0, 12'h123, seq[4]));
    end
    drain_n("wrap", 3);
    f_start = 32'd50; f_stop = 32'd10; start = 1'b1;
    drain_n("wrap_busy_start", 1);
    start = 1'b0;
    drain_n("wrap", 5);
    abort = 1'b1;
    sb_q.push_back(mk(0, 0, 0, 0, 0, 12'h123, V2));
    sb_q.push_back(mk(0, 0, 0, 0, 0, 12'h123, V2));
    @(posedge clk);
    #1 abort = 1'b0;
    drain("wrap_abort");

    // abort on the final dwell cycle: abort wins and no done pulse follows.
    do_start(32'd10, 32'd20, 32'd10, 16'd2, 1'b0, 12'h0F0);
    sb_q.push_back(mk(1, 1, 1, 0, 0, 12'h0F0, 32'd10));
    sb_q.push_back(mk(1, 1, 0, 0, 0, 12'h0F0, 32'd10));
    sb_q.push_back(mk(1, 1, 1, 0, 0, 12'h0F0, 32'd20));
    sb_q.push_back(mk(1, 1, 0, 0, 0, 12'h0F0, 32'd20));
    drain("last_abort_run");
    abort = 1'b1;
    sb_q.push_back(mk(0, 0, 0, 0, 0, 12'h0F0, 32'd20));
    sb_q.push_back(mk(0, 0, 0, 0, 0, 12'h0F0, 32'd20));
    @(posedge clk);
    #1 abort = 1'b0;
    drain("last_abort_idle");

    // Rejected start: cfg_err for exactly one cycle, busy stays low, and
    // fword holds its value.
    @(negedge clk);
    f_start = 32'd500; f_stop = 32'd100; f_step = 32'd1; dwell = 16'd1;
    mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sb_q.push_back(mk(0, 0, 0, 0, 1, 12'h0F0, 32'd20));
    sb_q.push_back(mk(0, 0, 0, 0, 0, 12'h0F0, 32'd20));
    drain("cfg_err");

    // start and abort together while idle, with a valid and then an invalid
    // configuration: nothing happens either time.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      f_start = 32'd1; f_stop = (k == 0) ? 32'd9 : 32'd0; f_step = 32'd1;
      dwell = 16'd1; start = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; abort = 1'b0;
      sb_q.push_back(mk(0, 0, 0, 0, 0, 12'h0F0, 32'd20));
      sb_q.push_back(mk(0, 0, 0, 0, 0, 12'h0F0, 32'd20));
      drain($sformatf("start_abort%0d", k));
    end

    // Reset mid-sweep: the outputs clear immediately, then a fresh sweep runs
    // normally.
    do_start(32'd100, 32'd400, 32'd100, 16'd3, 1'b0, 12'h077);
    sb_q.push_back(mk(1, 1, 1, 0, 0, 12'h077, 32'd100));
    sb_q.push_back(mk(1, 1, 0, 0, 0, 12'h077, 32'd100));
    sb_q.push_back(mk(1, 1, 0, 0, 0, 12'h077, 32'd100));
    sb_q.push_back(mk(1, 1, 1, 0, 0, 12'h077, 32'd200));
    drain("pre_reset");
    #2 rst_n = 1'b0;
    #1 check("reset_mid_async", sample(), mk(0, 0, 0, 0, 0, 12'h000, 32'h0));
    sb_q.delete();
    @(negedge clk);
    check("reset_mid_hold", sample(), mk(0, 0, 0, 0, 0, 12'h000, 32'h0));
    rst_n = 1'b1;
    run_vec("post_reset", tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Upstream control stage for the `dds` phase-accumulator core. It drives the core's `en`, `fword` and `pword` inputs so that the synthesized tone steps linearly from a start frequency word to a stop frequency word. Each frequency is held for a programmable dwell. Sweeps run once or repeat continuously. The block replaces the static frequency words currently written by the test harness and feeds the mixer/`per_filter` chain through the DDS.

## Interface
Parameters:
- `FW_W`, 32, frequency-word width; must match the `dds` `fword` width.
- `PW_W`, 12, phase-word width; must match the `dds` `pword` width.
- `DWELL_W`, 16, width of the dwell counter.

Ports:
- `clk` in 1: single system clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a sweep. Honoured only in IDLE.
- `abort` in 1: stops the sweep immediately. Takes priority over `start`.
- `mode` in 1: 0 = single sweep, 1 = continuous (wrap to start).
- `f_start` in FW_W: first frequency word.
- `f_stop` in FW_W: last permitted frequency word (inclusive).
- `f_step` in FW_W: increment per step.
- `dwell` in DWELL_W: cycles per frequency. A value of 0 is treated as 1.
- `p_offset` in PW_W: phase word, passed through registered.
- `fword` out FW_W: to `dds.fword`.
- `pword` out PW_W: to `dds.pword`.
- `en` out 1: to `dds.en`.
- `busy` out 1: high while a sweep is active.
- `step_tick` out 1: one-cycle pulse in each cycle that `fword` takes a new value.
- `done` out 1: one-cycle pulse at the natural end of a single sweep.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- **Configuration capture.** When a `start` is accepted, `f_start`, `f_stop`, `f_step`, `dwell` and `mode` are copied into shadow registers. Input changes after that point have no effect until the next accepted start.
- **Start rejection.** A start with `f_stop < f_start` (unsigned) is rejected:
  - `cfg_err` pulses for one cycle.
  - The block stays in IDLE.
- **States:**
  - **IDLE.**
    - Action: `en`=0, `busy`=0.
    - Exit: on `start & ~abort & cfg_ok`, go to RUN. On entry, `fword`←`f_start`, `en`=1, `busy`=1, `step_tick`=1, dwell counter←1.
  - **RUN.** Each cycle the counter increments. When counter == D (D = max(dwell,1)), the next value is chosen by the sum `nxt = fword + f_step`, computed at FW_W+1 bits (no overflow possible):
    - If `f_step`≠0 and `nxt` ≤ `f_stop`: `fword`←`nxt`, counter←1, `step_tick`=1.
    - Else, if mode=1: `fword`←`f_start`, counter←1, `step_tick`=1.
    - Else, if mode=0: go to IDLE with `done`=1, `en`=0, `busy`=0. `fword` holds its last value.
- **`f_step`=0.** Single mode ends after one dwell. Continuous mode re-loads `f_start` every D cycles; `step_tick` still pulses.
- **Abort.** `abort` in any state → IDLE on the next edge:
  - `en`=0, `busy`=0.
  - No `done` pulse.
  - `fword` holds its value.
- **Start while busy.** A `start` in RUN is ignored.
- **Phase word.** `pword` is registered from `p_offset` every cycle, independent of state.
- **Sweep length.** Single-sweep frequency count is K = floor((f_stop−f_start)/f_step)+1 for `f_step`≠0. `fword` never exceeds `f_stop`.

## Timing
- **Reset values:** `fword`=0, `pword`=0, `en`=0, `busy`=0, `step_tick`=0, `done`=0, `cfg_err`=0. State = IDLE, counter = 0, shadow registers = 0.
- **Start latency:** `start` sampled at edge N → `fword`=`f_start`, `en`=1 and `busy`=1 are visible after edge N.
- **Dwell:** each frequency value is present for exactly D cycles. Sweep duration is K·D cycles, from the first `en`=1 cycle to the first `en`=0 cycle. `done` is coincident with that first `en`=0 cycle.
- **Abort latency:** `abort` sampled at edge N → `en`=0 after edge N.
- **Simultaneous events:**
  - `abort` and `start` together in IDLE: ignored.
  - `abort` on the final dwell cycle: abort wins, no `done`.
- **Reset mid-sweep:** all outputs go to reset values immediately (asynchronously). No pulse outputs are emitted.
- **Pulse outputs:** `step_tick`, `done` and `cfg_err` are exactly one cycle wide. They are registered, not combinational.

## Test plan
- **Single sweep.** f_start=100, f_stop=400, f_step=100, dwell=3, mode=0 → `fword` = 100,200,300,400, each for 3 cycles. 4 `step_tick` pulses. `done` pulses 12 cycles after `en` rises. `fword` stays 400.
- **Non-aligned stop.** f_start=0, f_stop=250, f_step=100, dwell=0 → `fword` = 0,100,200, one cycle each. `done` on cycle 3. `fword` never reaches 300.
- **Continuous wrap.** f_start=42949672, f_step=42949672, f_stop=128849016, dwell=2, mode=1 → the 3-value sequence repeats. `done` never fires. Abort in the 5th step → `en`=0 the next cycle, no `done`.
- **Overflow guard.** f_start=32'hFFFF_FF00, f_stop=32'hFFFF_FFFF, f_step=32'h80 → values FF00 and FF80 only. No wrap to a small value. `done` after 2·D cycles.
- **Error and collision.** f_stop < f_start → `cfg_err`=1 for one cycle, `busy` stays 0. Then:
  - `start` while busy → ignored.
  - `start` and `abort` in the same cycle in IDLE → nothing happens.
- **Reset mid-sweep.** Deassert `rst_n` during RUN → all outputs 0 at once. After release, a new `start` sweeps normally from `f_start`.
